// File: rtl/nasti_stream_reader.sv
// nasti_stream_reader: streams a contiguous byte range read over NASTI AR/R out as a NASTI-Stream.
// Multiple outstanding bursts, 4KB splitting, credit-based buffering and sticky read-error flag.
`default_nettype none
module nasti_stream_reader #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int MAX_BURST_LENGTH = 8,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic                    o_src_ar_valid,
  input  logic                    i_src_ar_ready,
  output logic                    o_src_ar_id,
  output logic [ADDR_WIDTH-1:0]   o_src_ar_addr,
  output logic [7:0]              o_src_ar_len,
  output logic [2:0]              o_src_ar_size,
  output logic [1:0]              o_src_ar_burst,
  output logic                    o_src_ar_lock,
  output logic [3:0]              o_src_ar_cache,
  output logic [2:0]              o_src_ar_prot,
  output logic [3:0]              o_src_ar_qos,
  output logic [3:0]              o_src_ar_region,
  output logic                    o_src_ar_user,
  input  logic                    i_src_r_valid,
  output logic                    o_src_r_ready,
  input  logic [DATA_WIDTH-1:0]   i_src_r_data,
  input  logic [1:0]              i_src_r_resp,
  input  logic                    i_src_r_last,
  output logic                    o_src_aw_valid,
  output logic                    o_src_w_valid,
  output logic                    o_src_b_ready,
  output logic                    o_dest_t_valid,
  input  logic                    i_dest_t_ready,
  output logic [DATA_WIDTH-1:0]   o_dest_t_data,
  output logic [DATA_WIDTH/8-1:0] o_dest_t_strb,
  output logic [DATA_WIDTH/8-1:0] o_dest_t_keep,
  output logic                    o_dest_t_last,
  output logic                    o_dest_t_id,
  output logic                    o_dest_t_dest,
  output logic                    o_dest_t_user,
  input  logic [ADDR_WIDTH-1:0]   i_r_src,
  input  logic [ADDR_WIDTH-1:0]   i_r_len,
  input  logic                    i_r_valid,
  output logic                    o_r_ready,
  output logic                    o_r_err
);

  localparam int ADDR_SHIFT = $clog2(DATA_WIDTH/8);
  localparam int DEPTH      = MAX_BURST_LENGTH * MAX_OUTSTANDING;
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [12:0]      MBL     = 13'(MAX_BURST_LENGTH);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_issue_left, r_rcv_left;
  logic [OUT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_credits, r_fcnt;
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic                  r_err;
  logic [DATA_WIDTH:0]   r_mem [DEPTH];

  logic                  w_accept, w_ar_valid, w_ar_fire, w_r_fire, w_t_fire;
  logic [ADDR_WIDTH-1:0] w_beats;
  logic [12:0]           w_to4k, w_len_cap, w_len;
  logic                  w_unused_resp0;

  assign w_accept  = (r_state == S_IDLE) && i_r_valid;
  assign w_beats   = i_r_len >> ADDR_SHIFT;
  assign w_to4k    = (13'h1000 - {1'b0, r_addr[11:0]}) >> ADDR_SHIFT;
  assign w_len_cap = (MBL < w_to4k) ? MBL : w_to4k;
  assign w_len     = (r_issue_left < ADDR_WIDTH'(w_len_cap)) ? r_issue_left[12:0] : w_len_cap;

  // Valid depends only on registered state, so once raised it holds with stable fields until ar_ready.
  assign w_ar_valid = (r_state == S_ISSUE) && (r_issue_left != '0) &&
                      (r_outstanding < MAX_OUT) && (32'(r_credits) >= 32'(w_len));
  assign w_ar_fire  = w_ar_valid && i_src_ar_ready;
  assign w_r_fire   = i_src_r_valid;
  assign w_t_fire   = (r_fcnt != '0) && i_dest_t_ready;
  assign w_unused_resp0 = i_src_r_resp[0];

  assign o_src_ar_valid  = w_ar_valid;
  assign o_src_ar_id     = 1'b0;
  assign o_src_ar_addr   = r_addr;
  assign o_src_ar_len    = w_len[7:0] - 8'd1;
  assign o_src_ar_size   = 3'(ADDR_SHIFT);
  assign o_src_ar_burst  = 2'b01;
  assign o_src_ar_lock   = 1'b0;
  assign o_src_ar_cache  = 4'd0;
  assign o_src_ar_prot   = 3'd0;
  assign o_src_ar_qos    = 4'd0;
  assign o_src_ar_region = 4'd0;
  assign o_src_ar_user   = 1'b0;
  assign o_src_r_ready   = 1'b1;
  assign o_src_aw_valid  = 1'b0;
  assign o_src_w_valid   = 1'b0;
  assign o_src_b_ready   = 1'b0;

  assign o_dest_t_valid = (r_fcnt != '0);
  assign o_dest_t_data  = r_mem[r_rptr][DATA_WIDTH-1:0];
  assign o_dest_t_last  = r_mem[r_rptr][DATA_WIDTH];
  assign o_dest_t_strb  = '1;
  assign o_dest_t_keep  = '1;
  assign o_dest_t_id    = 1'b0;
  assign o_dest_t_dest  = 1'b0;
  assign o_dest_t_user  = 1'b0;

  assign o_r_ready = (r_state == S_IDLE);
  assign o_r_err   = r_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (w_beats != '0)) w_state_nxt = S_ISSUE;
      S_ISSUE: if (r_issue_left == '0) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_rcv_left == '0) && (r_outstanding == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_issue_left  <= '0;
      r_rcv_left    <= '0;
      r_outstanding <= '0;
      r_credits     <= CNT_W'(DEPTH);
      r_fcnt        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr       <= (i_r_src >> ADDR_SHIFT) << ADDR_SHIFT;
        r_issue_left <= w_beats;
        r_rcv_left   <= w_beats;
        r_err        <= 1'b0;
      end else begin
        if (w_ar_fire) begin
          r_addr       <= r_addr + (ADDR_WIDTH'(w_len) << ADDR_SHIFT);
          r_issue_left <= r_issue_left - ADDR_WIDTH'(w_len);
        end
        if (w_r_fire && (r_rcv_left != '0)) r_rcv_left <= r_rcv_left - 1'b1;
        if (w_r_fire && i_src_r_resp[1]) r_err <= 1'b1;
      end
      r_outstanding <= r_outstanding + OUT_W'(w_ar_fire) - OUT_W'(w_r_fire && i_src_r_last);
      // Credits reserve buffer space at AR time, so R beats never find the buffer full.
      r_credits <= r_credits - (w_ar_fire ? CNT_W'(w_len) : '0) + CNT_W'(w_t_fire);
      r_fcnt    <= r_fcnt + CNT_W'(w_r_fire) - CNT_W'(w_t_fire);
      if (w_r_fire) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_t_fire) r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_r_fire) r_mem[r_wptr] <= {(r_rcv_left == ADDR_WIDTH'(1)), i_src_r_data};
  end

`ifndef SYNTHESIS
  always_ff @(posedge aclk) begin
    if (aresetn && w_r_fire) begin
      assert (r_fcnt != CNT_W'(DEPTH));
      assert (r_outstanding != '0);
      assert (r_rcv_left != '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nasti_stream_reader.sv
// Bench for nasti_stream_reader: random-latency AXI read slave, random stream sink, and a
// queue-based reference model of the expected AR bursts and stream beats.
`timescale 1ns/1ps
`default_nettype none
module tb_nasti_stream_reader;
  localparam int AW = 64, DW = 64, MBL = 8, MO = 2;

  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          o_src_ar_valid, i_src_ar_ready = 1'b0, o_src_ar_id, o_src_ar_lock, o_src_ar_user;
  logic [AW-1:0] o_src_ar_addr;
  logic [7:0]    o_src_ar_len;
  logic [2:0]    o_src_ar_size, o_src_ar_prot;
  logic [1:0]    o_src_ar_burst;
  logic [3:0]    o_src_ar_cache, o_src_ar_qos, o_src_ar_region;
  logic          i_src_r_valid = 1'b0, o_src_r_ready, i_src_r_last = 1'b0;
  logic [DW-1:0] i_src_r_data = '0;
  logic [1:0]    i_src_r_resp = 2'b00;
  logic          o_src_aw_valid, o_src_w_valid, o_src_b_ready;
  logic          o_dest_t_valid, i_dest_t_ready = 1'b0, o_dest_t_last, o_dest_t_id, o_dest_t_dest, o_dest_t_user;
  logic [DW-1:0] o_dest_t_data;
  logic [DW/8-1:0] o_dest_t_strb, o_dest_t_keep;
  logic [AW-1:0] i_r_src = '0, i_r_len = '0;
  logic          i_r_valid = 1'b0, o_r_ready, o_r_err;

  nasti_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LENGTH(MBL), .MAX_OUTSTANDING(MO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .o_src_ar_valid(o_src_ar_valid), .i_src_ar_ready(i_src_ar_ready), .o_src_ar_id(o_src_ar_id),
    .o_src_ar_addr(o_src_ar_addr), .o_src_ar_len(o_src_ar_len), .o_src_ar_size(o_src_ar_size),
    .o_src_ar_burst(o_src_ar_burst), .o_src_ar_lock(o_src_ar_lock), .o_src_ar_cache(o_src_ar_cache),
    .o_src_ar_prot(o_src_ar_prot), .o_src_ar_qos(o_src_ar_qos), .o_src_ar_region(o_src_ar_region),
    .o_src_ar_user(o_src_ar_user),
    .i_src_r_valid(i_src_r_valid), .o_src_r_ready(o_src_r_ready), .i_src_r_data(i_src_r_data),
    .i_src_r_resp(i_src_r_resp), .i_src_r_last(i_src_r_last),
    .o_src_aw_valid(o_src_aw_valid), .o_src_w_valid(o_src_w_valid), .o_src_b_ready(o_src_b_ready),
    .o_dest_t_valid(o_dest_t_valid), .i_dest_t_ready(i_dest_t_ready), .o_dest_t_data(o_dest_t_data),
    .o_dest_t_strb(o_dest_t_strb), .o_dest_t_keep(o_dest_t_keep), .o_dest_t_last(o_dest_t_last),
    .o_dest_t_id(o_dest_t_id), .o_dest_t_dest(o_dest_t_dest), .o_dest_t_user(o_dest_t_user),
    .i_r_src(i_r_src), .i_r_len(i_r_len), .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .o_r_err(o_r_err)
  );

  typedef struct packed { logic [63:0] addr; logic [8:0] len; } burst_t;
  typedef struct packed { logic [63:0] data; logic last; } beat_t;

  burst_t exp_ar[$], obs_ar[$], slv_q[$];
  beat_t  exp_t[$], obs_t[$];
  burst_t env_b;
  int n_cmp = 0, n_err = 0;
  int slv_beat = 0, req_beat = 0, err_beat = -1, tready_mode = 0;
  int r_cnt = 0, t_cnt = 0, max_inflight = 0, const_bad = 0;
  bit r_fired = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_F00D, ~a[31:0]} ^ {a[63:32], 32'h0};
  endfunction

  // Expected bursts: greedy split by burst cap, remaining beats and distance to the next 4KB page.
  task automatic build_model(input logic [63:0] src, input logic [63:0] len);
    logic [63:0] a, left, n, room;
    exp_ar.delete();
    exp_t.delete();
    a    = src & ~64'h7;
    left = len >> 3;
    for (logic [63:0] i = 0; i < left; i++) exp_t.push_back({mem_word(a + i * 8), i == left - 1});
    while (left > 0) begin
      room = (64'd4096 - (a % 64'd4096)) / 8;
      n = MBL;
      if (left < n) n = left;
      if (room < n) n = room;
      exp_ar.push_back({a, n[8:0]});
      a    = a + n * 8;
      left = left - n;
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      slv_q.delete();
      slv_beat = 0;
      r_fired = 1'b0;
      i_src_r_valid = 1'b0; i_src_r_last = 1'b0; i_src_r_resp = 2'b00;
      i_src_ar_ready = 1'b0; i_dest_t_ready = 1'b0;
    end else begin
      if (r_fired) begin
        r_cnt++; req_beat++; slv_beat++;
        if (slv_beat == int'(slv_q[0].len)) begin
          void'(slv_q.pop_front());
          slv_beat = 0;
        end
      end
      if ((i_src_r_valid && !r_fired) || (slv_q.size() > 0 && $urandom_range(0, 3) != 0)) begin
        i_src_r_valid = 1'b1;
        i_src_r_data  = mem_word(slv_q[0].addr + 64'(slv_beat * 8));
        i_src_r_last  = (slv_beat == int'(slv_q[0].len) - 1);
        i_src_r_resp  = (req_beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        i_src_r_valid = 1'b0;
        i_src_r_last  = 1'b0;
      end
      r_fired = i_src_r_valid && o_src_r_ready;
      i_src_ar_ready = ($urandom_range(0, 2) != 0);
      if (o_src_ar_valid && i_src_ar_ready) begin
        env_b.addr = o_src_ar_addr;
        env_b.len  = 9'(o_src_ar_len) + 9'd1;
        obs_ar.push_back(env_b);
        slv_q.push_back(env_b);
        if (o_src_ar_size != 3'd3 || o_src_ar_burst != 2'b01 || o_src_ar_cache != 4'd0 || o_src_ar_id != 1'b0)
          const_bad++;
      end
      case (tready_mode)
        1:       i_dest_t_ready = 1'b0;
        2:       i_dest_t_ready = 1'b1;
        default: i_dest_t_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (o_dest_t_valid && i_dest_t_ready) begin
        obs_t.push_back({o_dest_t_data, o_dest_t_last});
        t_cnt++;
        if (o_dest_t_strb != '1 || o_dest_t_keep != '1) const_bad++;
      end
      if (r_cnt - t_cnt > max_inflight) max_inflight = r_cnt - t_cnt;
    end
  end

  task automatic run_req(input logic [63:0] src, input logic [63:0] len, input int eb,
                         input int stall, input string tag);
    int cyc;
    int n;
    build_model(src, len);
    obs_ar.delete(); obs_t.delete();
    err_beat = eb; req_beat = 0; r_cnt = 0; t_cnt = 0; max_inflight = 0;
    tready_mode = (stall > 0) ? 1 : 0;
    cyc = 0;
    while (!o_r_ready && cyc < 1000) begin @(negedge aclk); cyc++; end
    i_r_src = src; i_r_len = len; i_r_valid = 1'b1;
    @(negedge aclk);
    i_r_valid = 1'b0;
    check({tag, "_ready_after_accept"}, o_r_ready, (len >> 3) == 0);
    check({tag, "_err_cleared"}, o_r_err, 1'b0);
    if (stall > 0) begin
      repeat (stall) @(negedge aclk);
      check({tag, "_stall_inflight_le16"}, (r_cnt - t_cnt) <= 2 * MBL, 1'b1);
      check({tag, "_stall_ar_le2"}, obs_ar.size() <= MO, 1'b1);
      check({tag, "_stall_no_output"}, obs_t.size(), 0);
      tready_mode = 2;
    end
    cyc = 0;
    while ((obs_t.size() < exp_t.size() || !o_r_ready) && cyc < 3000) begin @(negedge aclk); cyc++; end
    check({tag, "_completes"}, cyc < 3000, 1'b1);
    repeat (4) @(negedge aclk);
    check({tag, "_ar_count"}, obs_ar.size(), exp_ar.size());
    n = (obs_ar.size() < exp_ar.size()) ? obs_ar.size() : exp_ar.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ar%0d_addr", tag, i), obs_ar[i].addr, exp_ar[i].addr);
      check($sformatf("%s_ar%0d_len", tag, i), obs_ar[i].len, exp_ar[i].len);
    end
    check({tag, "_beat_count"}, obs_t.size(), exp_t.size());
    n = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_beat%0d_data", tag, i), obs_t[i].data, exp_t[i].data);
      check($sformatf("%s_beat%0d_last", tag, i), obs_t[i].last, exp_t[i].last);
    end
    check({tag, "_err_flag"}, o_r_err, (eb >= 0) && (64'(eb) < (len >> 3)));
    check({tag, "_ready_end"}, o_r_ready, 1'b1);
    check({tag, "_buffer_bound"}, max_inflight <= 2 * MBL, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rs, rl;
    int eb;
    repeat (3) @(negedge aclk);
    check("reset_r_ready", o_r_ready, 1'b1);
    check("reset_r_err", o_r_err, 1'b0);
    check("reset_ar_valid", o_src_ar_valid, 1'b0);
    check("reset_t_valid", o_dest_t_valid, 1'b0);
    check("write_side_idle", {o_src_aw_valid, o_src_w_valid, o_src_b_ready}, 3'b000);
    aresetn = 1'b1;
    @(negedge aclk);

    run_req(64'h1000, 64'h40, -1, 0, "one_burst");
    run_req(64'h1000, 64'h58, -1, 0, "partial_tail");
    run_req(64'h0FE0, 64'h40, -1, 0, "split_4k");
    run_req(64'h3000, 64'h200, -1, 40, "backpressure");
    run_req(64'h2000, 64'h40, 2, 0, "slverr");
    run_req(64'h2100, 64'h40, -1, 0, "err_clears");
    run_req(64'h5008, 64'h0, -1, 0, "zero_len");
    run_req(64'hFFFF_FFFF_FFFF_FFE0, 64'h40, -1, 0, "addr_wrap");
    for (int k = 0; k < 6; k++) begin
      rs = 64'($urandom_range(0, 3)) * 4096 + 64'($urandom_range(0, 511)) * 8 + 64'($urandom_range(0, 7));
      rl = 64'($urandom_range(0, 48)) * 8 + 64'($urandom_range(0, 7));
      eb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 47)) : -1;
      run_req(rs, rl, eb, 0, $sformatf("rand%0d", k));
    end

    build_model(64'h8000, 64'h200);
    tready_mode = 0;
    i_r_src = 64'h8000; i_r_len = 64'h200; i_r_valid = 1'b1;
    @(negedge aclk);
    i_r_valid = 1'b0;
    repeat (12) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midreset_r_ready", o_r_ready, 1'b1);
    check("midreset_ar_valid", o_src_ar_valid, 1'b0);
    check("midreset_t_valid", o_dest_t_valid, 1'b0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    run_req(64'h2000, 64'h20, -1, 0, "after_reset");

    check("const_fields", const_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
